// File: rtl/dp_mul_responder_if.sv
// Operand/result handshake bundle for the binary64 multiplier.
// Initiator drives operands with stb; responder acks and returns z.
interface dp_mul_responder_if;
   logic [63:0] input_a;
   logic        input_a_stb;
   logic        input_a_ack;
   logic [63:0] input_b;
   logic        input_b_stb;
   logic        input_b_ack;
   logic [63:0] output_z;
   logic        output_z_stb;
   logic        output_z_ack;

   modport master (
      output input_a, input_a_stb,
      input  input_a_ack,
      output input_b, input_b_stb,
      input  input_b_ack,
      input  output_z, output_z_stb,
      output output_z_ack
   );

   modport slave (
      input  input_a, input_a_stb,
      output input_a_ack,
      input  input_b, input_b_stb,
      output input_b_ack,
      output output_z, output_z_stb,
      input  output_z_ack
   );
endinterface

// File: rtl/dp_mul_responder.sv
// IEEE-754 binary64 multiplier, responder side of stb/ack handshake.
// Round-to-nearest-even, flush-to-zero on subnormal inputs/results.
module dp_mul_responder #(
   parameter logic [63:0] QNAN = 64'h7FF8000000000000
) (
   input logic               clk,
   input logic               rst,
   dp_mul_responder_if.slave bus
);

   typedef enum logic [3:0] {
      GET_A, GET_B, UNPACK, SPECIAL, MULTIPLY,
      NORMALISE, ROUND, PACK, PUT_Z, IDLE
   } state_t;

   state_t              state_q, state_d;
   logic [63:0]         a_q, a_d, b_q, b_d;
   logic [63:0]         z_q, z_d;
   logic                a_ack_q, a_ack_d;
   logic                b_ack_q, b_ack_d;
   logic                z_stb_q, z_stb_d;
   logic                s_q, s_d;
   logic signed [12:0]  ea_q, ea_d, eb_q, eb_d;
   logic signed [12:0]  e_q, e_d;
   logic [52:0]         ma_q, ma_d, mb_q, mb_d;
   logic                az_q, az_d, bz_q, bz_d;
   logic                ai_q, ai_d, bi_q, bi_d;
   logic                an_q, an_d, bn_q, bn_d;
   logic [105:0]        prod_q, prod_d;
   logic [52:0]         m_q, m_d;
   logic                g_q, g_d, r_q, r_d, st_q, st_d;

   assign bus.input_a_ack  = a_ack_q;
   assign bus.input_b_ack  = b_ack_q;
   assign bus.output_z     = z_q;
   assign bus.output_z_stb = z_stb_q;

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= GET_A;
         a_q     <= '0;
         b_q     <= '0;
         z_q     <= '0;
         a_ack_q <= 1'b1;
         b_ack_q <= 1'b0;
         z_stb_q <= 1'b0;
         s_q     <= 1'b0;
         ea_q    <= '0;
         eb_q    <= '0;
         e_q     <= '0;
         ma_q    <= '0;
         mb_q    <= '0;
         az_q    <= 1'b0;
         bz_q    <= 1'b0;
         ai_q    <= 1'b0;
         bi_q    <= 1'b0;
         an_q    <= 1'b0;
         bn_q    <= 1'b0;
         prod_q  <= '0;
         m_q     <= '0;
         g_q     <= 1'b0;
         r_q     <= 1'b0;
         st_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         z_q     <= z_d;
         a_ack_q <= a_ack_d;
         b_ack_q <= b_ack_d;
         z_stb_q <= z_stb_d;
         s_q     <= s_d;
         ea_q    <= ea_d;
         eb_q    <= eb_d;
         e_q     <= e_d;
         ma_q    <= ma_d;
         mb_q    <= mb_d;
         az_q    <= az_d;
         bz_q    <= bz_d;
         ai_q    <= ai_d;
         bi_q    <= bi_d;
         an_q    <= an_d;
         bn_q    <= bn_d;
         prod_q  <= prod_d;
         m_q     <= m_d;
         g_q     <= g_d;
         r_q     <= r_d;
         st_q    <= st_d;
      end
   end

   // Sequencing, handshakes and one arithmetic step per state.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      z_d     = z_q;
      a_ack_d = a_ack_q;
      b_ack_d = b_ack_q;
      z_stb_d = z_stb_q;
      s_d     = s_q;
      ea_d    = ea_q;
      eb_d    = eb_q;
      e_d     = e_q;
      ma_d    = ma_q;
      mb_d    = mb_q;
      az_d    = az_q;
      bz_d    = bz_q;
      ai_d    = ai_q;
      bi_d    = bi_q;
      an_d    = an_q;
      bn_d    = bn_q;
      prod_d  = prod_q;
      m_d     = m_q;
      g_d     = g_q;
      r_d     = r_q;
      st_d    = st_q;

      unique case (state_q)
         GET_A: begin
            a_ack_d = 1'b1;
            if (bus.input_a_stb && a_ack_q) begin
               a_d     = bus.input_a;
               a_ack_d = 1'b0;
               b_ack_d = 1'b1;
               state_d = GET_B;
            end
         end
         GET_B: begin
            b_ack_d = 1'b1;
            if (bus.input_b_stb && b_ack_q) begin
               b_d     = bus.input_b;
               b_ack_d = 1'b0;
               state_d = UNPACK;
            end
         end
         UNPACK: begin
            s_d   = a_q[63] ^ b_q[63];
            ea_d  = $signed({2'b00, a_q[62:52]}) - 13'sd1023;
            eb_d  = $signed({2'b00, b_q[62:52]}) - 13'sd1023;
            ma_d  = {1'b1, a_q[51:0]};
            mb_d  = {1'b1, b_q[51:0]};
            az_d  = (a_q[62:52] == 11'h000);
            bz_d  = (b_q[62:52] == 11'h000);
            ai_d  = (a_q[62:52] == 11'h7FF) && (a_q[51:0] == '0);
            bi_d  = (b_q[62:52] == 11'h7FF) && (b_q[51:0] == '0);
            an_d  = (a_q[62:52] == 11'h7FF) && (a_q[51:0] != '0);
            bn_d  = (b_q[62:52] == 11'h7FF) && (b_q[51:0] != '0);
            state_d = SPECIAL;
         end
         SPECIAL: begin
            state_d = PUT_Z;
            z_stb_d = 1'b1;
            if (an_q || bn_q) begin
               z_d = QNAN;
            end else if ((ai_q && bz_q) || (bi_q && az_q)) begin
               z_d = QNAN;
            end else if (ai_q || bi_q) begin
               z_d = {s_q, 11'h7FF, 52'd0};
            end else if (az_q || bz_q) begin
               z_d = {s_q, 63'd0};
            end else begin
               z_stb_d = 1'b0;
               state_d = MULTIPLY;
            end
         end
         MULTIPLY: begin
            prod_d  = {53'd0, ma_q} * {53'd0, mb_q};
            e_d     = ea_q + eb_q;
            state_d = NORMALISE;
         end
         NORMALISE: begin
            if (prod_q[105]) begin
               m_d  = prod_q[105:53];
               g_d  = prod_q[52];
               r_d  = prod_q[51];
               st_d = |prod_q[50:0];
               e_d  = e_q + 13'sd1;
            end else begin
               m_d  = prod_q[104:52];
               g_d  = prod_q[51];
               r_d  = prod_q[50];
               st_d = |prod_q[49:0];
            end
            state_d = ROUND;
         end
         ROUND: begin
            if (g_q && (r_q || st_q || m_q[0])) begin
               if (&m_q) begin
                  m_d = {1'b1, 52'd0};
                  e_d = e_q + 13'sd1;
               end else begin
                  m_d = m_q + 53'd1;
               end
            end
            state_d = PACK;
         end
         PACK: begin
            if (e_q > 13'sd1023) begin
               z_d = {s_q, 11'h7FF, 52'd0};
            end else if (e_q < -13'sd1022) begin
               z_d = {s_q, 63'd0};
            end else begin
               z_d = {s_q, 11'(e_q + 13'sd1023), m_q[51:0]};
            end
            z_stb_d = 1'b1;
            state_d = PUT_Z;
         end
         PUT_Z: begin
            if (z_stb_q && bus.output_z_ack) begin
               z_stb_d = 1'b0;
               state_d = IDLE;
            end
         end
         IDLE: begin
            a_ack_d = 1'b1;
            state_d = GET_A;
         end
         default: state_d = GET_A;
      endcase
   end

endmodule

// File: tb/tb_dp_mul_responder.sv
// Bench for dp_mul_responder: directed cases plus random operands
// checked against a real-arithmetic reference with FTZ/NaN rules.
module tb_dp_mul_responder;
   localparam logic [63:0] QNAN = 64'h7FF8000000000000;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   dp_mul_responder_if bus ();

   dp_mul_responder #(.QNAN(QNAN)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   task automatic check(input string tag,
                        input logic [63:0] obs,
                        input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit is_nan(input logic [63:0] x);
      return x[62:52] == 11'h7FF && x[51:0] != 52'd0;
   endfunction

   function automatic bit is_inf(input logic [63:0] x);
      return x[62:52] == 11'h7FF && x[51:0] == 52'd0;
   endfunction

   function automatic bit is_zero(input logic [63:0] x);
      return x[62:52] == 11'h000;
   endfunction

   function automatic bit is_special(input logic [63:0] a,
                                     input logic [63:0] b);
      return is_nan(a) || is_nan(b) || is_inf(a) || is_inf(b) ||
             is_zero(a) || is_zero(b);
   endfunction

   function automatic logic [63:0] ref_mul(input logic [63:0] a,
                                           input logic [63:0] b);
      logic        s;
      logic [63:0] r;
      s = a[63] ^ b[63];
      if (is_nan(a) || is_nan(b)) return QNAN;
      if ((is_inf(a) && is_zero(b)) || (is_inf(b) && is_zero(a)))
         return QNAN;
      if (is_inf(a) || is_inf(b)) return {s, 11'h7FF, 52'd0};
      if (is_zero(a) || is_zero(b)) return {s, 63'd0};
      r = $realtobits($bitstoreal(a) * $bitstoreal(b));
      if (r[62:52] == 11'h000) return {s, 63'd0};
      return r;
   endfunction

   function automatic logic [63:0] gen_operand(input int kind);
      logic [63:0] x;
      logic [10:0] e;
      x[51:0] = {$urandom, $urandom};
      x[63]   = 1'($urandom_range(1));
      if (kind == 0) e = 11'($urandom_range(1346, 700));
      else e = 11'($urandom_range(2046, 1));
      x[62:52] = e;
      return x;
   endfunction

   // Present both operands together; A must be taken strictly before B.
   task automatic send_ab(input logic [63:0] a, input logic [63:0] b);
      int n;
      bus.input_a     = a;
      bus.input_b     = b;
      bus.input_a_stb = 1'b1;
      bus.input_b_stb = 1'b1;
      n = 0;
      while (bus.input_a_ack !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("a_ack_wait", 64'(bus.input_a_ack), 64'd1);
      check("b_ack_not_with_a", 64'(bus.input_b_ack), 64'd0);
      @(negedge clk);
      bus.input_a_stb = 1'b0;
      bus.input_a     = {$urandom, $urandom};
      n = 0;
      while (bus.input_b_ack !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("b_ack_wait", 64'(bus.input_b_ack), 64'd1);
      @(negedge clk);
      bus.input_b_stb = 1'b0;
      bus.input_b     = {$urandom, $urandom};
   endtask

   task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                         input int hold, input bit linger);
      logic [63:0] exp_z;
      logic [63:0] held_z;
      int          exp_lat;
      int          n;
      exp_z   = ref_mul(a, b);
      exp_lat = is_special(a, b) ? 2 : 6;
      send_ab(a, b);
      n = 0;
      while (bus.output_z_stb !== 1'b1 && n < 30) begin
         @(negedge clk);
         n++;
      end
      check("latency", 64'(n), 64'(exp_lat));
      check("z", bus.output_z, exp_z);
      held_z = exp_z;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_stb", 64'(bus.output_z_stb), 64'd1);
         check("hold_z", bus.output_z, held_z);
      end
      bus.output_z_ack = 1'b1;
      if (linger) begin
         bus.input_a_stb = 1'b1;
         bus.input_b_stb = 1'b1;
      end
      @(negedge clk);
      bus.output_z_ack = 1'b0;
      check("stb_drop", 64'(bus.output_z_stb), 64'd0);
      check("idle_a_ack", 64'(bus.input_a_ack), 64'd0);
      check("idle_b_ack", 64'(bus.input_b_ack), 64'd0);
      bus.input_a_stb = 1'b0;
      bus.input_b_stb = 1'b0;
      @(negedge clk);
      check("a_ack_back", 64'(bus.input_a_ack), 64'd1);
      check("b_ack_low", 64'(bus.input_b_ack), 64'd0);
   endtask

   initial begin
      logic [63:0] ra, rb;
      rst = 1'b1;
      bus.input_a      = '0;
      bus.input_b      = '0;
      bus.input_a_stb  = 1'b0;
      bus.input_b_stb  = 1'b0;
      bus.output_z_ack = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("rst_a_ack", 64'(bus.input_a_ack), 64'd1);
      check("rst_b_ack", 64'(bus.input_b_ack), 64'd0);
      check("rst_z_stb", 64'(bus.output_z_stb), 64'd0);
      check("rst_z", bus.output_z, 64'd0);

      run_op(64'h4000000000000000, 64'h4008000000000000, 0, 0);
      check("two_x_three", ref_mul(64'h4000000000000000,
                                   64'h4008000000000000),
            64'h4018000000000000);
      run_op(64'h3FF0000000000001, 64'h3FF0000000000001, 0, 0);
      run_op(64'h3FF0000000000000, 64'hBFE0000000000000, 1, 0);
      run_op(64'h7FF0000000000000, 64'h0000000000000000, 0, 0);
      run_op(64'hFFF0000000000000, 64'h4000000000000000, 0, 0);
      run_op(64'h7FF0000000000001, 64'h3FF0000000000000, 0, 0);
      run_op(64'h0000000000000001, 64'hC000000000000000, 0, 0);
      run_op(64'h7FE0000000000000, 64'h4000000000000000, 0, 0);
      run_op(64'h0170000000000000, 64'h39B0000000000000, 0, 0);
      run_op(64'h3FF8000000000000, 64'hC00C000000000000, 10, 1);

      send_ab(64'h4000000000000000, 64'h4008000000000000);
      repeat (2) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      check("mid_rst_a_ack", 64'(bus.input_a_ack), 64'd1);
      check("mid_rst_b_ack", 64'(bus.input_b_ack), 64'd0);
      check("mid_rst_z_stb", 64'(bus.output_z_stb), 64'd0);
      check("mid_rst_z", bus.output_z, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("post_rst_no_z", 64'(bus.output_z_stb), 64'd0);
      run_op(64'h4000000000000000, 64'h4008000000000000, 0, 0);

      for (int i = 0; i < 40; i++) begin
         ra = gen_operand(i % 4 == 3 ? 1 : 0);
         rb = gen_operand(i % 4 == 3 ? 1 : 0);
         if (i % 9 == 4) ra = {ra[63], 11'h000, ra[51:0]};
         if (i % 11 == 5) rb = {rb[63], 11'h7FF, 52'd0};
         if (i % 13 == 6) ra = {ra[63], 11'h7FF, ra[51:1], 1'b1};
         run_op(ra, rb, int'($urandom_range(3)), 1'($urandom_range(1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
